registro_id_ex: RTL and testbench
=================================

# registro_id_ex

Pipeline register between decode (ID) and execute (EX) of the MIPS32 core, with integrated load-use hazard detection. It latches the main control unit's decoded control bundle together with register operands, extended immediate, register specifiers and PC+4. On a load-use dependency it inserts a single-cycle bubble and stalls PC and IF/ID. It consumes the control unit's outputs directly and feeds the EX stage, the forwarding unit and the EX/MEM register.

## Interface
- `DW`, 32, datapath width (operands, immediate, PC+4)
- `RW`, 5, register specifier width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  global advance enable; 0 freezes the register (memory wait)
- `flush`  in  1  branch/jump taken downstream; squash ID instruction
- `id_RegDest, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump, id_is_byte, id_is_unsigned`  in  1 each  control unit outputs
- `id_ALUOp`  in  2  control unit ALUOp (00 add, 01 branch, 10 R-type, 11 logic)
- `id_pc4, id_rd1, id_rd2, id_imm`  in  DW each  PC+4, register file read data, sign-extended immediate
- `id_rs, id_rt, id_rd`  in  RW each  instruction fields
- `id_funct`  in  6  funct field
- `ex_*`  out  same widths  registered copies of every `id_*` input
- `ex_valid`  out  1  EX slot holds a real instruction (0 = bubble)
- `stall`  out  1  combinational; 1 = hold PC and IF/ID this cycle

## Operation
- Hazard detection (combinational, from current `ex_*` and `id_*`): `stall = ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt))`.
- `uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch`.
- `stall` is forced to 0 when `flush` = 1.
- Register update priority at each rising edge:
  1. `flush`: load a bubble.
  2. `en` = 0: hold all contents.
  3. `stall`: load a bubble.
  4. Otherwise: load all `id_*` inputs and set `ex_valid` = 1.
- Bubble: all control outputs (`ex_RegDest` … `ex_is_unsigned`, `ex_ALUOp`) = 0 and `ex_valid` = 0. Data/specifier fields load normally; their value is don't-care.
- A bubble clears `ex_MemRead`, so a load-use stall self-terminates after exactly one cycle.
- Two back-to-back dependent consumers behind one load produce only one bubble. The second consumer is covered by forwarding, not by this block.
- No arithmetic; all fields pass through width-preserving.

## Timing
- Latency: one cycle, ID input to `ex_*` output.
- `stall` is valid in the same cycle as the ID inputs. It has no register, so the upstream PC/IF-ID write enables must consume it combinationally.
- Reset (`rst_n` = 0, asynchronous): every `ex_*` output = 0, `ex_valid` = 0, hence `stall` = 0.
- Reset released mid-operation: the first post-reset edge loads normally.
- `flush` and `stall` in the same cycle: the bubble is loaded, `stall` = 0, and the flushed ID instruction is discarded.
- `en` = 0 together with `stall` = 1: contents are held and `stall` stays asserted; the bubble is inserted at the first edge with `en` = 1.
- `flush` overrides `en` = 0, so a squash is never lost during a freeze.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams
  - ALUOp encodings (`ALUOP_ADD`, `ALUOP_BR`, `ALUOP_R`, `ALUOP_LOGIC`)
  - control bundle width (`CTRL_W` = 12) and bit positions, so the bundle is registered as one vector
- Sub-module `detector_riesgos`: purely combinational load-use detector producing `stall`; instantiated once.

## Test plan
- Reset asserted mid-stream with `ex_RegWrite`=1 -> all outputs 0 immediately, before the next edge.
- ADD $3,$1,$2 (`id_RegDest`=1, `id_ALUOp`=10, `id_rd1`=5, `id_rd2`=7) -> next cycle `ex_ALUOp`=10, `ex_rd1`=5, `ex_rd2`=7, `ex_valid`=1, `stall`=0.
- LW $4,0($1) followed by ADD $5,$4,$2 -> `stall`=1 for one cycle, one bubble (`ex_valid`=0, `ex_RegWrite`=0), then ADD enters EX.
- LW $0,... followed by a $0 consumer -> `stall`=0; LW $4 followed by ADDI $4,$6,1 (`id_rt`=4, ALUSrc=1) -> `stall`=0.
- Load-use with `flush`=1 in the same cycle -> `stall`=0, bubble loaded.
- `en`=0 for 3 cycles during a stall -> outputs frozen, `stall` held high; bubble on the first `en`=1 edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcodes, ALUOp encodings and control bundle layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_R     = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  // The whole decoded control word travels as one vector; a bubble is all zeros.
  localparam int CTRL_W         = 12;
  localparam int CB_REGDEST     = 0;
  localparam int CB_BRANCH      = 1;
  localparam int CB_MEMREAD     = 2;
  localparam int CB_MEMTOREG    = 3;
  localparam int CB_MEMWRITE    = 4;
  localparam int CB_ALUSRC      = 5;
  localparam int CB_REGWRITE    = 6;
  localparam int CB_JUMP        = 7;
  localparam int CB_IS_BYTE     = 8;
  localparam int CB_IS_UNSIGNED = 9;
  localparam int CB_ALUOP_LO    = 10;
  localparam int CB_ALUOP_HI    = 11;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/detector_riesgos.sv
// Combinational load-use hazard detector for the ID/EX boundary.
module detector_riesgos
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_alu_src,
  input  logic          id_mem_write,
  input  logic          id_branch,
  input  logic          flush,
  output logic          stall
);

  logic uses_rt;
  logic load_in_ex;
  logic dep;

  // rt is a true source for R-type, stores (data) and branches (compare).
  always_comb begin
    uses_rt    = ~id_alu_src | id_mem_write | id_branch;
    load_in_ex = ex_valid & ex_mem_read & (ex_rt != '0);
    dep        = (ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt);
    // A flushed ID instruction is discarded anyway, so it must not stall.
    stall      = load_in_ex & dep & ~flush;
  end

endmodule

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register with integrated load-use bubble insertion.
module registro_id_ex
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          id_RegDest,
  input  logic          id_Branch,
  input  logic          id_MemRead,
  input  logic          id_MemtoReg,
  input  logic          id_MemWrite,
  input  logic          id_ALUSrc,
  input  logic          id_RegWrite,
  input  logic          id_Jump,
  input  logic          id_is_byte,
  input  logic          id_is_unsigned,
  input  logic [1:0]    id_ALUOp,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [5:0]    id_funct,
  output logic          ex_RegDest,
  output logic          ex_Branch,
  output logic          ex_MemRead,
  output logic          ex_MemtoReg,
  output logic          ex_MemWrite,
  output logic          ex_ALUSrc,
  output logic          ex_RegWrite,
  output logic          ex_Jump,
  output logic          ex_is_byte,
  output logic          ex_is_unsigned,
  output logic [1:0]    ex_ALUOp,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [5:0]    ex_funct,
  output logic          ex_valid,
  output logic          stall
);

  logic [CTRL_W-1:0] id_ctrl;
  logic [CTRL_W-1:0] ctrl_q;

  // Pack the control unit outputs into one vector so a bubble is a single clear.
  always_comb begin
    id_ctrl                             = '0;
    id_ctrl[CB_REGDEST]                 = id_RegDest;
    id_ctrl[CB_BRANCH]                  = id_Branch;
    id_ctrl[CB_MEMREAD]                 = id_MemRead;
    id_ctrl[CB_MEMTOREG]                = id_MemtoReg;
    id_ctrl[CB_MEMWRITE]                = id_MemWrite;
    id_ctrl[CB_ALUSRC]                  = id_ALUSrc;
    id_ctrl[CB_REGWRITE]                = id_RegWrite;
    id_ctrl[CB_JUMP]                    = id_Jump;
    id_ctrl[CB_IS_BYTE]                 = id_is_byte;
    id_ctrl[CB_IS_UNSIGNED]             = id_is_unsigned;
    id_ctrl[CB_ALUOP_HI:CB_ALUOP_LO]    = id_ALUOp;
  end

  detector_riesgos #(.RW(RW)) u_detector (
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_MemRead),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_alu_src   (id_ALUSrc),
    .id_mem_write (id_MemWrite),
    .id_branch    (id_Branch),
    .flush        (flush),
    .stall        (stall)
  );

  // Control/valid: flush beats the freeze so a squash is never lost; stall inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      ex_valid <= 1'b0;
    end else if (flush) begin
      ctrl_q   <= CTRL_BUBBLE;
      ex_valid <= 1'b0;
    end else if (en) begin
      if (stall) begin
        ctrl_q   <= CTRL_BUBBLE;
        ex_valid <= 1'b0;
      end else begin
        ctrl_q   <= id_ctrl;
        ex_valid <= 1'b1;
      end
    end
  end

  // Data and specifier fields; contents under a bubble are don't-care, so they just follow ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_funct <= '0;
    end else if (flush || en) begin
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_funct <= id_funct;
    end
  end

  // Unpack the registered control vector onto the named EX outputs.
  always_comb begin
    ex_RegDest     = ctrl_q[CB_REGDEST];
    ex_Branch      = ctrl_q[CB_BRANCH];
    ex_MemRead     = ctrl_q[CB_MEMREAD];
    ex_MemtoReg    = ctrl_q[CB_MEMTOREG];
    ex_MemWrite    = ctrl_q[CB_MEMWRITE];
    ex_ALUSrc      = ctrl_q[CB_ALUSRC];
    ex_RegWrite    = ctrl_q[CB_REGWRITE];
    ex_Jump        = ctrl_q[CB_JUMP];
    ex_is_byte     = ctrl_q[CB_IS_BYTE];
    ex_is_unsigned = ctrl_q[CB_IS_UNSIGNED];
    ex_ALUOp       = ctrl_q[CB_ALUOP_HI:CB_ALUOP_LO];
  end

endmodule

// File: tb/tb_registro_id_ex.sv
// Directed bench for registro_id_ex: reset, pass-through, load-use bubbles, flush and freeze.
module tb_registro_id_ex;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, en, flush;
  logic          id_RegDest, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite;
  logic          id_ALUSrc, id_RegWrite, id_Jump, id_is_byte, id_is_unsigned;
  logic [1:0]    id_ALUOp;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]    id_funct;
  logic          ex_RegDest, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite;
  logic          ex_ALUSrc, ex_RegWrite, ex_Jump, ex_is_byte, ex_is_unsigned;
  logic [1:0]    ex_ALUOp;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]    ex_funct;
  logic          ex_valid, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  registro_id_ex #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .id_RegDest(id_RegDest), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
    .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_RegWrite(id_RegWrite), .id_Jump(id_Jump), .id_is_byte(id_is_byte),
    .id_is_unsigned(id_is_unsigned), .id_ALUOp(id_ALUOp),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .ex_RegDest(ex_RegDest), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
    .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegWrite(ex_RegWrite), .ex_Jump(ex_Jump), .ex_is_byte(ex_is_byte),
    .ex_is_unsigned(ex_is_unsigned), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    {id_RegDest, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite} = '0;
    {id_ALUSrc, id_RegWrite, id_Jump, id_is_byte, id_is_unsigned} = '0;
    id_ALUOp = 2'b00;
    id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0;
  endtask

  // R-type ADD rd, rs, rt
  task automatic drive_add(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    clear_id();
    id_RegDest = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b10;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rd1 = a; id_rd2 = b;
    id_funct = 6'h20; id_pc4 = 32'h0000_0104;
  endtask

  // LW rt, 0(rs)
  task automatic drive_lw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    clear_id();
    id_MemRead = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b1; id_ALUSrc = 1'b1;
    id_rs = rs; id_rt = rt; id_pc4 = 32'h0000_0100;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0;
    clear_id();
    #3;
    chk("reset_valid", ex_valid, 0);
    chk("reset_stall", stall, 0);
    #4 rst_n = 1'b1;

    // ADD $3,$1,$2
    drive_add(1, 2, 3, 5, 7);
    tick();
    chk("add_aluop", ex_ALUOp, 2'b10);
    chk("add_rd1", ex_rd1, 5);
    chk("add_rd2", ex_rd2, 7);
    chk("add_valid", ex_valid, 1);
    chk("add_regdest", ex_RegDest, 1);
    chk("add_stall", stall, 0);

    // Asynchronous reset between edges while ex_RegWrite=1
    #1 rst_n = 1'b0;
    #1;
    chk("arst_regwrite", ex_RegWrite, 0);
    chk("arst_valid", ex_valid, 0);
    chk("arst_rd1", ex_rd1, 0);
    chk("arst_aluop", ex_ALUOp, 0);
    drive_add(1, 2, 3, 9, 11);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset_valid", ex_valid, 1);
    chk("post_reset_rd1", ex_rd1, 9);

    // LW $4,0($1) then ADD $5,$4,$2
    drive_lw(1, 4);
    #1 chk("lw_no_stall", stall, 0);
    tick();
    chk("lw_memread", ex_MemRead, 1);
    drive_add(4, 2, 5, 1, 2);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_regwrite", ex_RegWrite, 0);
    chk("lu_bubble_memread", ex_MemRead, 0);
    chk("lu_stall_released", stall, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 5);
    chk("lu_add_regwrite", ex_RegWrite, 1);
    // Second consumer of $4 after the bubble: no further stall
    drive_add(4, 4, 6, 0, 0);
    #1 chk("second_consumer_stall", stall, 0);
    tick();

    // LW $4 then SW $4,0($7): rt is a source for stores
    drive_lw(1, 4);
    tick();
    clear_id();
    id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_rs = 7; id_rt = 4;
    #1 chk("sw_rt_stall", stall, 1);
    tick();
    chk("sw_bubble_valid", ex_valid, 0);

    // LW $0 then consumer of $0
    drive_lw(1, 0);
    tick();
    drive_add(0, 0, 5, 0, 0);
    #1 chk("zero_reg_stall", stall, 0);
    tick();
    chk("zero_reg_valid", ex_valid, 1);

    // LW $4 then ADDI $4,$6,1: rt is a destination, not a source
    drive_lw(1, 4);
    tick();
    clear_id();
    id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_rs = 6; id_rt = 4; id_imm = 1;
    #1 chk("addi_stall", stall, 0);
    tick();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 1);

    // Load-use with flush in the same cycle
    drive_lw(1, 4);
    tick();
    drive_add(4, 2, 5, 0, 0);
    flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_regwrite", ex_RegWrite, 0);

    // en=0 for three cycles during a stall
    drive_lw(1, 4);
    tick();
    drive_add(4, 2, 5, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_memread", ex_MemRead, 1);
      chk("frz_valid", ex_valid, 1);
      chk("frz_rt", ex_rt, 4);
      chk("frz_stall", stall, 1);
    end
    en = 1'b1;
    tick();
    chk("frz_bubble_valid", ex_valid, 0);
    chk("frz_bubble_stall", stall, 0);
    tick();
    chk("frz_add_valid", ex_valid, 1);
    chk("frz_add_rd", ex_rd, 5);

    // Flush overrides a freeze
    en = 1'b0; flush = 1'b1;
    tick();
    chk("flush_over_en_valid", ex_valid, 0);
    chk("flush_over_en_regwrite", ex_RegWrite, 0);
    flush = 1'b0; en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
